// File: rtl/sevenseg_scan_capture.sv
`default_nettype none
// ============================================================================
// Module   : sevenseg_scan_capture
// Purpose  : Rebuilds the four digits shown on a scanned 7-segment bus and
//            presents them as a coherent frame with a one-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan_capture #(
    parameter int SETTLE_CYCLES    = 16,
    parameter int FRAME_TIMEOUT    = 16384,
    parameter int ANODE_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] segments,
    input  logic [3:0] anodes,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] blank,
    output logic [3:0] invalid,
    output logic       frame_valid,
    output logic       multi_anode_err,
    output logic       stale
);

    localparam int c_CNT_W = $clog2(SETTLE_CYCLES);
    localparam int c_TO_W  = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SETTLE = c_CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [c_TO_W-1:0]  c_TO_MAX     = c_TO_W'(FRAME_TIMEOUT);

    // Returns {invalid, blank, value}
    function automatic logic [5:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   f_decode = 6'h00;
            7'h06:   f_decode = 6'h01;
            7'h5B:   f_decode = 6'h02;
            7'h4F:   f_decode = 6'h03;
            7'h66:   f_decode = 6'h04;
            7'h6D:   f_decode = 6'h05;
            7'h7D:   f_decode = 6'h06;
            7'h07:   f_decode = 6'h07;
            7'h7F:   f_decode = 6'h08;
            7'h6F:   f_decode = 6'h09;
            7'h77:   f_decode = 6'h0A;
            7'h7C:   f_decode = 6'h0B;
            7'h39:   f_decode = 6'h0C;
            7'h5E:   f_decode = 6'h0D;
            7'h79:   f_decode = 6'h0E;
            7'h71:   f_decode = 6'h0F;
            7'h00:   f_decode = 6'h10;
            default: f_decode = 6'h20;
        endcase
    endfunction

    logic [6:0]         r_seg_s1, r_seg_s2;
    logic [3:0]         r_an_s1, r_an_s2;
    logic [10:0]        r_prev;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_captured;
    logic [3:0]         r_seen;
    logic               r_frame_pend;
    logic [3:0][3:0]    r_slot_val;
    logic [3:0]         r_slot_blank;
    logic [3:0]         r_slot_inv;
    logic [3:0]         r_digit0, r_digit1, r_digit2, r_digit3;
    logic [3:0]         r_blank, r_invalid;
    logic               r_frame_valid, r_multi_err;
    logic [c_TO_W-1:0]  r_to_cnt;

    logic [6:0]  w_seg;
    logic [3:0]  w_an;
    logic [10:0] w_cur;
    logic        w_same, w_settle, w_onehot, w_multi, w_capture;
    logic [1:0]  w_idx;
    logic [5:0]  w_dec;
    logic [3:0]  w_seen_upd;

    assign w_seg      = ~r_seg_s2;
    assign w_an       = (ANODE_ACTIVE_LOW != 0) ? ~r_an_s2 : r_an_s2;
    assign w_cur      = {w_an, w_seg};
    assign w_same     = (w_cur == r_prev);
    // Fires on the sample that makes SETTLE_CYCLES identical samples in a row
    assign w_settle   = w_same && (r_cnt == c_CNT_SETTLE) && !r_captured;
    assign w_onehot   = $onehot(w_an);
    assign w_multi    = (w_an != 4'b0000) && !w_onehot;
    assign w_capture  = w_settle && w_onehot;
    assign w_idx      = w_an[3] ? 2'd3 : w_an[2] ? 2'd2 : w_an[1] ? 2'd1 : 2'd0;
    assign w_dec      = f_decode(w_seg);
    assign w_seen_upd = r_seen | w_an;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1 <= '0;
            r_seg_s2 <= '0;
            r_an_s1  <= '0;
            r_an_s2  <= '0;
        end else begin
            r_seg_s1 <= segments;
            r_seg_s2 <= r_seg_s1;
            r_an_s1  <= anodes;
            r_an_s2  <= r_an_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_cnt        <= '0;
            r_captured   <= 1'b0;
            r_multi_err  <= 1'b0;
            r_slot_val   <= '0;
            r_slot_blank <= '0;
            r_slot_inv   <= '0;
        end else begin
            r_prev      <= w_cur;
            r_multi_err <= w_settle && w_multi;
            if (!w_same) begin
                r_cnt      <= '0;
                r_captured <= 1'b0;
            end else begin
                if (r_cnt != c_CNT_MAX)
                    r_cnt <= r_cnt + 1'b1;
                if (w_settle)
                    r_captured <= 1'b1;
            end
            if (w_capture) begin
                r_slot_val[w_idx]   <= w_dec[3:0];
                r_slot_blank[w_idx] <= w_dec[4];
                r_slot_inv[w_idx]   <= w_dec[5];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen        <= '0;
            r_frame_pend  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_digit0      <= '0;
            r_digit1      <= '0;
            r_digit2      <= '0;
            r_digit3      <= '0;
            r_blank       <= '0;
            r_invalid     <= '0;
        end else if (r_frame_pend) begin
            // Publish the frame; a capture landing now starts the next one
            r_frame_pend  <= 1'b0;
            r_frame_valid <= 1'b1;
            r_digit0      <= r_slot_val[0];
            r_digit1      <= r_slot_val[1];
            r_digit2      <= r_slot_val[2];
            r_digit3      <= r_slot_val[3];
            r_blank       <= r_slot_blank;
            r_invalid     <= r_slot_inv;
            r_seen        <= w_capture ? w_an : 4'b0000;
        end else begin
            r_frame_valid <= 1'b0;
            if (w_capture) begin
                r_seen <= w_seen_upd;
                if (w_seen_upd == 4'b1111)
                    r_frame_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (r_frame_pend)
            r_to_cnt <= '0;
        else if (r_to_cnt != c_TO_MAX)
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign digit0          = r_digit0;
    assign digit1          = r_digit1;
    assign digit2          = r_digit2;
    assign digit3          = r_digit3;
    assign blank           = r_blank;
    assign invalid         = r_invalid;
    assign frame_valid     = r_frame_valid;
    assign multi_anode_err = r_multi_err;
    assign stale           = (r_to_cnt == c_TO_MAX);

endmodule
`default_nettype wire
